// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, defaults and address helper for the data-memory access path
//
// Contents:
//   dmem_state_e      : access FSM states (IDLE, ACCESS, DONE)
//   DMEM_BASE_ADDR    : default byte address of data word 0
//   DMEM_MEM_SIZE     : default data memory depth in words
//   DMEM_WAIT_CYCLES  : default access length in cycles (1..15)
//   DMEM_CNT_W        : wait-counter width, wide enough for WAIT_CYCLES-1 up to 14
//   addr_to_idx()     : byte address -> word offset from the segment base

package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } dmem_state_e;

  localparam int DMEM_BASE_ADDR   = 1024;
  localparam int DMEM_MEM_SIZE    = 64;
  localparam int DMEM_WAIT_CYCLES = 4;
  localparam int DMEM_CNT_W       = 4;

  // Word offset of a byte address from the segment base. The two byte-lane
  // bits are dropped; callers truncate the result to their index width, which
  // makes below-base addresses wrap to the top of the index space.
  function automatic logic [31:0] addr_to_idx(input logic [31:0] add,
                                              input logic [31:0] base);
    logic [31:0] off;
    off = add - base;
    return {2'b00, off[31:2]};
  endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// rtl/dmem_wait_counter.sv - loadable down-counter with zero flag for memory wait states
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; saturates at zero
//   count      : current count
//   zero       : count == 0

module dmem_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store initiator for the word-addressed data memory
//
// Converts MEM-stage byte-address requests into word-indexed, fixed-length
// memory accesses and freezes the pipeline (ready=0) until each completes.
// Optional address range check: define DMEM_ADDR_CHECK_EN.
//
// Ports:
//   clk, rst             : clock (rising edge), asynchronous active-low reset
//   MEM_R_EN, MEM_W_EN   : load / store request (store wins if both set)
//   Add, input_data      : byte address and store data
//   ready                : 1 = pipeline may advance, 0 = freeze
//   out_data             : registered load result
//   addr_err             : one-cycle pulse on an out-of-range request (check build only)
//   mem_idx, mem_wdata   : word index and write data to memory
//   mem_read, mem_write  : memory read enable (whole access), write pulse (last cycle)
//   mem_rdata            : memory read data, valid while mem_read is high

import dmem_pkg::*;

module dmem_access_ctrl #(
  parameter int LEN         = 32,
  parameter int BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int MEM_SIZE    = DMEM_MEM_SIZE,
  parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES,
  parameter int IDX_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  input  logic [LEN-1:0]   Add,
  input  logic [LEN-1:0]   input_data,
  output logic             ready,
  output logic [LEN-1:0]   out_data,
  output logic             addr_err,
  output logic [IDX_W-1:0] mem_idx,
  output logic [LEN-1:0]   mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [LEN-1:0]   mem_rdata
);

  dmem_state_e          state_d, state_q;
  logic                 op_write_d, op_write_q;
  logic [IDX_W-1:0]     idx_d, idx_q;
  logic [LEN-1:0]       wdata_d, wdata_q;
  logic [LEN-1:0]       out_data_d, out_data_q;

  logic                 req;
  logic                 in_range;
  logic                 issue;
  logic [IDX_W-1:0]     req_idx;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [DMEM_CNT_W-1:0] cnt_value;

  assign req     = MEM_R_EN | MEM_W_EN;
  assign req_idx = IDX_W'(addr_to_idx(32'(Add), 32'(BASE_ADDR)));

`ifdef DMEM_ADDR_CHECK_EN
  // One extra bit so the upper bound cannot overflow at the top of the address space.
  localparam int             CW    = LEN + 1;
  localparam logic [CW-1:0]  LO_BA = CW'(BASE_ADDR);
  localparam logic [CW-1:0]  HI_BA = CW'(BASE_ADDR + 4 * MEM_SIZE);

  logic addr_err_d, addr_err_q;

  assign in_range = ({1'b0, Add} >= LO_BA) && ({1'b0, Add} < HI_BA);

  // A rejected request never leaves IDLE; it only raises the error pulse.
  always_comb begin
    addr_err_d = (state_q == ST_IDLE) && req && !in_range;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;
`else
  assign in_range = 1'b1;
  assign addr_err = 1'b0;
`endif

  assign issue    = req && in_range;
  assign cnt_load = (state_q == ST_IDLE) && issue;
  assign cnt_dec  = (state_q == ST_ACCESS) && !cnt_zero;

  dmem_wait_counter #(
    .W (DMEM_CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst_n    (rst),
    .load     (cnt_load),
    .load_val (DMEM_CNT_W'(WAIT_CYCLES - 1)),
    .dec      (cnt_dec),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    out_data_d = out_data_q;
    ready      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // ready drops in the request cycle itself so the pipeline freezes at once.
        ready = !issue;
        if (issue) begin
          state_d    = ST_ACCESS;
          op_write_d = MEM_W_EN;
          idx_d      = req_idx;
          wdata_d    = input_data;
        end
      end
      ST_ACCESS: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
          if (!op_write_q) begin
            out_data_d = mem_rdata;
          end
        end
      end
      ST_DONE: begin
        // Pipeline advances now; a still-asserted enable belongs to the old request.
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      out_data_q <= out_data_d;
    end
  end

  assign mem_idx   = idx_q;
  assign mem_wdata = wdata_q;
  assign out_data  = out_data_q;
  assign mem_read  = (state_q == ST_ACCESS) && !op_write_q;
  assign mem_write = (state_q == ST_ACCESS) && op_write_q && cnt_zero;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Pipeline-side initiator for the word-addressed data memory.
- Takes MEM-stage load/store requests (byte address, store data, read/write enables) and converts byte addresses to word indices relative to the data-segment base.
- Drives the memory with a fixed wait-state access sequence and holds the pipeline via ready until the access completes.
- Sits between the EXE/MEM pipeline register and the data memory.

Parameters:
- LEN, 32, data and byte-address width
- BASE_ADDR, 1024, byte address of data word 0
- MEM_SIZE, 64, number of words in the data memory
- WAIT_CYCLES, 4, memory access length in cycles; legal range 1..15
- IDX_W, 6, word-index width; must be at least clog2(MEM_SIZE)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- MEM_R_EN  in  1  load request from MEM stage
- MEM_W_EN  in  1  store request from MEM stage
- Add  in  LEN  byte address (ALU result)
- input_data  in  LEN  store data
- ready  out  1  high = pipeline may advance; low = freeze
- out_data  out  LEN  registered load result
- addr_err  out  1  one-cycle pulse on an out-of-range request (feature only)
- mem_idx  out  IDX_W  word index to memory
- mem_wdata  out  LEN  write data to memory
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable (single-cycle pulse)
- mem_rdata  in  LEN  memory read data, valid combinationally while mem_read is high

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, counter=0, out_data=0.
  - mem_read=0, mem_write=0, mem_idx=0, mem_wdata=0, addr_err=0.
  - ready=1 while in IDLE with no request.
- Index computation: idx = (Add - BASE_ADDR) >> 2, truncated to IDX_W. Add[1:0] is ignored.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - With no request, ready=1.
  - A request (MEM_R_EN|MEM_W_EN) makes ready=0 combinationally in the same cycle.
  - Next edge: latch idx, input_data, and operation; counter=WAIT_CYCLES-1; go to ACCESS.
  - If both enables are high, the write wins and the read is dropped.
- ACCESS:
  - ready=0 throughout.
  - mem_read=1 for the whole state on loads.
  - mem_write=1 only when counter==0 on stores.
  - counter decrements each cycle.
  - When counter==0: a load captures mem_rdata into out_data at that edge; go to DONE.
  - Total ACCESS length is exactly WAIT_CYCLES cycles.
- DONE:
  - ready=1 for exactly one cycle; memory enables are 0.
  - Go to IDLE unconditionally. A request still visible in DONE is not re-issued; the pipeline advances on this cycle.
- Freeze length per access = WAIT_CYCLES+1 cycles, counting the request cycle in IDLE.
- out_data holds its last value across stores and idle cycles.
- Reset mid-ACCESS: abort immediately, no write pulse, out_data=0.
- Request enables that change during ACCESS are ignored; the operands latched in IDLE are used.

Optional Feature:
- Macro: DMEM_ADDR_CHECK_EN
- Defined:
  - A request with Add < BASE_ADDR or Add >= BASE_ADDR + 4*MEM_SIZE is not issued.
  - The FSM stays in IDLE and ready stays 1.
  - addr_err pulses high for one cycle after the request edge.
  - A load leaves out_data=0.
- Undefined:
  - No range check; the index wraps modulo 2^IDX_W.
  - addr_err is tied to 0.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum (IDLE, ACCESS, DONE);
  - BASE_ADDR, MEM_SIZE and WAIT_CYCLES defaults;
  - an addr_to_idx function.
- One natural sub-module: dmem_wait_counter (load/decrement/zero-flag), reusable for an instruction-memory wait path.

Test Plan:
- Load, WAIT_CYCLES=4, memory word 2 = 0xDEADBEEF, Add=1032, MEM_R_EN=1:
  - ready low for 5 cycles;
  - mem_idx=2 and mem_read high for 4 cycles;
  - out_data=0xDEADBEEF in DONE.
- Store Add=1024, input_data=0x12345678:
  - exactly one mem_write pulse in the last ACCESS cycle, mem_idx=0, mem_wdata=0x12345678;
  - a following load of 1024 returns 0x12345678.
- MEM_R_EN=MEM_W_EN=1, Add=1028: mem_write pulses once, mem_read stays 0, out_data unchanged.
- Back-to-back loads (1024 then 1028) with the enable held through DONE: two separate accesses, no extra access issued in DONE.
- rst=0 asserted in the 2nd ACCESS cycle of a store: mem_write never pulses; all outputs reset; ready=1 after release.
- DMEM_ADDR_CHECK_EN defined, Add=1020 load: no memory enable, ready stays 1, addr_err one pulse, out_data=0. Undefined: access proceeds with mem_idx=63.
